// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage
//  Purpose  : Instruction-fetch stage of the pipelined MIPS datapath. Holds
//             the PC, fetches from instruction memory over a req/ready
//             handshake, applies next-PC redirects selected in ID and drives
//             the IF/ID pipeline register whose opcode/func fields feed the
//             decode-stage controller.
//  Ports    : clk, rst_n           - clock, async active-low reset
//             stall                - hazard-unit freeze of IF/ID and PC
//             if_flush             - load a bubble into IF/ID
//             pc_src               - 00 seq, 01 branch, 10 jump, 11 jr
//             branch_target,
//             jump_target,
//             jr_target            - redirect targets computed in ID
//             imem_req, imem_addr  - fetch request / word-aligned address
//             imem_ready,
//             imem_rdata           - memory response
//             ifid_instr,
//             ifid_pc_plus4,
//             ifid_valid           - IF/ID pipeline register
//             opcode, func         - decoded fields of ifid_instr
//  Revision : 1.0 - initial release
// ============================================================================
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        if_flush,
   input  logic [1:0]  pc_src,
   input  logic [31:0] branch_target,
   input  logic [31:0] jump_target,
   input  logic [31:0] jr_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc_plus4,
   output logic        ifid_valid,
   output logic [5:0]  opcode,
   output logic [5:0]  func
);

   // Fetch FSM encoding
   localparam logic [1:0] ST_FETCH   = 2'd0;  // request at pc
   localparam logic [1:0] ST_HOLD    = 2'd1;  // word captured during stall
   localparam logic [1:0] ST_DISCARD = 2'd2;  // drain a stale request

   localparam logic [1:0] SRC_SEQ    = 2'b00;
   localparam logic [1:0] SRC_BRANCH = 2'b01;
   localparam logic [1:0] SRC_JUMP   = 2'b10;

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   logic [1:0]  state;
   logic [1:0]  state_nxt;
   logic [31:0] pc;
   logic [31:0] pc_nxt;
   logic [31:0] stale_addr;
   logic [31:0] stale_addr_nxt;
   logic [31:0] hold_instr;
   logic [31:0] hold_instr_nxt;
   logic [31:0] ifid_instr_nxt;
   logic [31:0] ifid_pc_plus4_nxt;
   logic        ifid_valid_nxt;

   logic [31:0] pc_plus4;
   logic [31:0] redirect_target;
   logic        redirect;

   // PC+4 wraps naturally at 2^32
   assign pc_plus4 = pc + 32'd4;

   // A redirect chosen in ID only takes effect when the pipe is not frozen
   assign redirect = (pc_src != SRC_SEQ) && !stall;

   always_comb begin
      redirect_target = jr_target;
      case (pc_src)
         SRC_BRANCH: redirect_target = branch_target;
         SRC_JUMP:   redirect_target = jump_target;
         default:    redirect_target = jr_target;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         ST_FETCH: begin
            if (stall) begin
               // A word arriving while frozen is parked rather than lost
               if (imem_ready) state_nxt = ST_HOLD;
            end else if (redirect && !imem_ready) begin
               // The outstanding request must complete before the address
               // may move, so its result is drained and dropped first
               state_nxt = ST_DISCARD;
            end
         end
         ST_HOLD: begin
            if (!stall) state_nxt = ST_FETCH;
         end
         ST_DISCARD: begin
            if (imem_ready) state_nxt = ST_FETCH;
         end
         default: state_nxt = ST_FETCH;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: output logic (memory request side)
   // ------------------------------------------------------------------
   always_comb begin
      imem_req  = 1'b0;
      imem_addr = {pc[31:2], 2'b00};
      case (state)
         ST_FETCH: begin
            imem_req  = 1'b1;
            imem_addr = {pc[31:2], 2'b00};
         end
         ST_HOLD: begin
            imem_req  = 1'b0;
            imem_addr = {pc[31:2], 2'b00};
         end
         ST_DISCARD: begin
            // Keep presenting the old address until the memory answers
            imem_req  = 1'b1;
            imem_addr = {stale_addr[31:2], 2'b00};
         end
         default: begin
            imem_req  = 1'b0;
            imem_addr = {pc[31:2], 2'b00};
         end
      endcase
      // No request may be seen while the stage is held in reset
      if (!rst_n) imem_req = 1'b0;
   end

   // ------------------------------------------------------------------
   // Datapath next-value logic
   // ------------------------------------------------------------------
   always_comb begin
      pc_nxt            = pc;
      stale_addr_nxt    = stale_addr;
      hold_instr_nxt    = hold_instr;
      ifid_instr_nxt    = ifid_instr;
      ifid_pc_plus4_nxt = ifid_pc_plus4;
      ifid_valid_nxt    = ifid_valid;

      case (state)
         ST_FETCH: begin
            if (stall) begin
               // IF/ID and pc frozen; only capture a returning word
               if (imem_ready) hold_instr_nxt = imem_rdata;
            end else if (redirect) begin
               pc_nxt            = redirect_target;
               ifid_instr_nxt    = 32'h0;
               ifid_pc_plus4_nxt = 32'h0;
               ifid_valid_nxt    = 1'b0;
               if (!imem_ready) stale_addr_nxt = pc;
            end else if (imem_ready) begin
               // The fetched slot is consumed even when flushed
               pc_nxt = pc_plus4;
               if (if_flush) begin
                  ifid_instr_nxt    = 32'h0;
                  ifid_pc_plus4_nxt = 32'h0;
                  ifid_valid_nxt    = 1'b0;
               end else begin
                  ifid_instr_nxt    = imem_rdata;
                  ifid_pc_plus4_nxt = pc_plus4;
                  ifid_valid_nxt    = 1'b1;
               end
            end else begin
               ifid_instr_nxt    = 32'h0;
               ifid_pc_plus4_nxt = 32'h0;
               ifid_valid_nxt    = 1'b0;
            end
         end

         ST_HOLD: begin
            if (!stall) begin
               if (redirect) begin
                  pc_nxt            = redirect_target;
                  ifid_instr_nxt    = 32'h0;
                  ifid_pc_plus4_nxt = 32'h0;
                  ifid_valid_nxt    = 1'b0;
               end else begin
                  pc_nxt = pc_plus4;
                  if (if_flush) begin
                     ifid_instr_nxt    = 32'h0;
                     ifid_pc_plus4_nxt = 32'h0;
                     ifid_valid_nxt    = 1'b0;
                  end else begin
                     ifid_instr_nxt    = hold_instr;
                     ifid_pc_plus4_nxt = pc_plus4;
                     ifid_valid_nxt    = 1'b1;
                  end
               end
            end
         end

         ST_DISCARD: begin
            // Nothing useful can reach IF/ID while draining; a later
            // redirect simply retargets pc
            if (!stall) begin
               ifid_instr_nxt    = 32'h0;
               ifid_pc_plus4_nxt = 32'h0;
               ifid_valid_nxt    = 1'b0;
               if (redirect) pc_nxt = redirect_target;
            end
         end

         default: begin
            pc_nxt = pc;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc            <= RESET_PC;
         stale_addr    <= 32'h0;
         hold_instr    <= 32'h0;
         ifid_instr    <= 32'h0;
         ifid_pc_plus4 <= 32'h0;
         ifid_valid    <= 1'b0;
      end else begin
         pc            <= pc_nxt;
         stale_addr    <= stale_addr_nxt;
         hold_instr    <= hold_instr_nxt;
         ifid_instr    <= ifid_instr_nxt;
         ifid_pc_plus4 <= ifid_pc_plus4_nxt;
         ifid_valid    <= ifid_valid_nxt;
      end
   end

   // Controller-facing fields are plain slices of the IF/ID register
   assign opcode = ifid_instr[31:26];
   assign func   = ifid_instr[5:0];

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_stage
//  Purpose  : Directed self-checking bench for if_stage. Instruction memory
//             returns (32'hA000_0000 ^ address) for every word, so each
//             expected IF/ID value below is written out as a constant.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        if_flush;
   logic [1:0]  pc_src;
   logic [31:0] branch_target;
   logic [31:0] jump_target;
   logic [31:0] jr_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc_plus4;
   logic        ifid_valid;
   logic [5:0]  opcode;
   logic [5:0]  func;

   int checks;
   int errors;

   if_stage #(
      .RESET_PC(32'h0000_0100)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (stall),
      .if_flush     (if_flush),
      .pc_src       (pc_src),
      .branch_target(branch_target),
      .jump_target  (jump_target),
      .jr_target    (jr_target),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .imem_rdata   (imem_rdata),
      .ifid_instr   (ifid_instr),
      .ifid_pc_plus4(ifid_pc_plus4),
      .ifid_valid   (ifid_valid),
      .opcode       (opcode),
      .func         (func)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory model
   assign imem_rdata = 32'hA000_0000 ^ imem_addr;

   // Advance one cycle and settle just after the active edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; stall = 1'b0; if_flush = 1'b0; pc_src = 2'b00;
      branch_target = 32'h0; jump_target = 32'h0; jr_target = 32'h0;
      imem_ready = 1'b1;
      tick(); tick();
      checks++;
      if ({imem_req, ifid_instr, ifid_pc_plus4, ifid_valid} !== {1'b0, 32'h0, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: req=%0b instr=%h pc4=%h valid=%0b, need 0/0/0/0",
                  imem_req, ifid_instr, ifid_pc_plus4, ifid_valid);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h0000_0100}) begin
         errors++;
         $display("FAIL first_fetch: req=%0b addr=%h, need 1/00000100", imem_req, imem_addr);
      end
      tick();
      checks++;
      if ({imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, opcode}
          !== {32'h0000_0104, 32'hA000_0100, 32'h0000_0104, 1'b1, 6'h28}) begin
         errors++;
         $display("FAIL seq_cycle1: addr=%h instr=%h pc4=%h valid=%0b op=%h, need 104/A0000100/104/1/28",
                  imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, opcode);
      end
      tick();
      checks++;
      if ({imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, func}
          !== {32'h0000_0108, 32'hA000_0104, 32'h0000_0108, 1'b1, 6'h04}) begin
         errors++;
         $display("FAIL seq_cycle2: addr=%h instr=%h pc4=%h valid=%0b func=%h, need 108/A0000104/108/1/04",
                  imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, func);
      end
   endtask

   // pc = 0x108, memory ready; freeze for two cycles
   task automatic test_stall();
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({imem_req, ifid_instr, ifid_pc_plus4, ifid_valid}
             !== {1'b0, 32'hA000_0104, 32'h0000_0108, 1'b1}) begin
            errors++;
            $display("FAIL stall_hold%0d: req=%0b instr=%h pc4=%h valid=%0b, need 0/A0000104/108/1",
                     i, imem_req, ifid_instr, ifid_pc_plus4, ifid_valid);
         end
      end
      stall = 1'b0;
      tick();
      checks++;
      if ({imem_req, imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid}
          !== {1'b1, 32'h0000_010C, 32'hA000_0108, 32'h0000_010C, 1'b1}) begin
         errors++;
         $display("FAIL stall_release: req=%0b addr=%h instr=%h pc4=%h valid=%0b, need 1/10C/A0000108/10C/1",
                  imem_req, imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid);
      end
      tick();
      checks++;
      if ({imem_addr, ifid_instr, ifid_pc_plus4} !== {32'h0000_0110, 32'hA000_010C, 32'h0000_0110}) begin
         errors++;
         $display("FAIL stall_after: addr=%h instr=%h pc4=%h, need 110/A000010C/110",
                  imem_addr, ifid_instr, ifid_pc_plus4);
      end
   endtask

   // pc = 0x110; branch with IFflush, then a plain flush
   task automatic test_branch_flush();
      pc_src = 2'b01; branch_target = 32'h0000_0200; if_flush = 1'b1;
      tick();
      pc_src = 2'b00; if_flush = 1'b0;
      checks++;
      if ({imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, opcode}
          !== {32'h0000_0200, 32'h0, 32'h0, 1'b0, 6'h00}) begin
         errors++;
         $display("FAIL branch_bubble: addr=%h instr=%h pc4=%h valid=%0b op=%h, need 200/0/0/0/00",
                  imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, opcode);
      end
      tick();
      checks++;
      if ({imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid}
          !== {32'h0000_0204, 32'hA000_0200, 32'h0000_0204, 1'b1}) begin
         errors++;
         $display("FAIL branch_target: addr=%h instr=%h pc4=%h valid=%0b, need 204/A0000200/204/1",
                  imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid);
      end
      if_flush = 1'b1;
      tick();
      if_flush = 1'b0;
      checks++;
      if ({imem_addr, ifid_instr, ifid_valid} !== {32'h0000_0208, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL flush_only: addr=%h instr=%h valid=%0b, need 208/0/0",
                  imem_addr, ifid_instr, ifid_valid);
      end
   endtask

   // pc = 0x208; jr while the memory is slow
   task automatic test_discard_jr();
      imem_ready = 1'b0; pc_src = 2'b11; jr_target = 32'h0000_03C0;
      tick();
      pc_src = 2'b00;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({imem_req, imem_addr, ifid_valid} !== {1'b1, 32'h0000_0208, 1'b0}) begin
            errors++;
            $display("FAIL discard_wait%0d: req=%0b addr=%h valid=%0b, need 1/208/0",
                     i, imem_req, imem_addr, ifid_valid);
         end
         if (i < 2) tick();
      end
      imem_ready = 1'b1;
      tick();
      checks++;
      if ({imem_addr, ifid_instr, ifid_valid} !== {32'h0000_03C0, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL discard_drop: addr=%h instr=%h valid=%0b, need 3C0/0/0",
                  imem_addr, ifid_instr, ifid_valid);
      end
      tick();
      checks++;
      if ({imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid}
          !== {32'h0000_03C4, 32'hA000_03C0, 32'h0000_03C4, 1'b1}) begin
         errors++;
         $display("FAIL jr_target: addr=%h instr=%h pc4=%h valid=%0b, need 3C4/A00003C0/3C4/1",
                  imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid);
      end
   endtask

   // pc = 0x3C4; jump ignored under stall, then PC wrap
   task automatic test_jump_stall_wrap();
      pc_src = 2'b10; jump_target = 32'hFFFF_FFFC; stall = 1'b1;
      tick();
      checks++;
      if ({imem_req, ifid_instr, ifid_pc_plus4} !== {1'b0, 32'hA000_03C0, 32'h0000_03C4}) begin
         errors++;
         $display("FAIL jump_stalled: req=%0b instr=%h pc4=%h, need 0/A00003C0/3C4",
                  imem_req, ifid_instr, ifid_pc_plus4);
      end
      stall = 1'b0; pc_src = 2'b00;
      tick();
      checks++;
      if ({imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid}
          !== {32'h0000_03C8, 32'hA000_03C4, 32'h0000_03C8, 1'b1}) begin
         errors++;
         $display("FAIL no_redirect: addr=%h instr=%h pc4=%h valid=%0b, need 3C8/A00003C4/3C8/1",
                  imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid);
      end
      pc_src = 2'b10;
      tick();
      pc_src = 2'b00;
      checks++;
      if ({imem_addr, ifid_valid} !== {32'hFFFF_FFFC, 1'b0}) begin
         errors++;
         $display("FAIL jump_taken: addr=%h valid=%0b, need FFFFFFFC/0", imem_addr, ifid_valid);
      end
      tick();
      checks++;
      if ({imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, opcode, func}
          !== {32'h0000_0000, 32'h5FFF_FFFC, 32'h0000_0000, 1'b1, 6'h17, 6'h3C}) begin
         errors++;
         $display("FAIL pc_wrap: addr=%h instr=%h pc4=%h valid=%0b op=%h func=%h, need 0/5FFFFFFC/0/1/17/3C",
                  imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, opcode, func);
      end
   endtask

   // pc = 0x0; enter DISCARD, then reset asynchronously
   task automatic test_reset_mid_discard();
      tick();
      imem_ready = 1'b0; pc_src = 2'b01; branch_target = 32'h0000_0500;
      tick();
      pc_src = 2'b00;
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h0000_0004}) begin
         errors++;
         $display("FAIL discard_enter: req=%0b addr=%h, need 1/00000004", imem_req, imem_addr);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({imem_req, imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid}
          !== {1'b0, 32'h0000_0100, 32'h0, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL async_reset: req=%0b addr=%h instr=%h pc4=%h valid=%0b, need 0/100/0/0/0",
                  imem_req, imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid);
      end
      imem_ready = 1'b1;
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if ({imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid}
          !== {32'h0000_0104, 32'hA000_0100, 32'h0000_0104, 1'b1}) begin
         errors++;
         $display("FAIL restart: addr=%h instr=%h pc4=%h valid=%0b, need 104/A0000100/104/1",
                  imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_stall();
      test_branch_flush();
      test_discard_jr();
      test_jump_stall_wrap();
      test_reset_mid_discard();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
